// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with pipeline stall request and abort.
module ex_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t                state, state_nxt;
  logic                  load, step, finish, spec_ld;
  logic [CNT_WIDTH-1:0]  cnt;
  // Low half holds the multiplier (multiply) or the dividend/quotient (divide).
  logic [2*XLEN-1:0]     acc;
  logic [XLEN:0]         rem;
  logic [XLEN-1:0]       mcand;
  logic [2:0]            f3;
  logic                  neg_res, neg_rem;

  logic signed [XLEN-1:0] op1_s, op2_s;
  logic                  signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  div_zero, div_ovf, special;
  logic [XLEN-1:0]       special_res;

  assign op1_s    = op1;
  assign op2_s    = op2;
  assign signed_a = (funct3 == F_MULH) || (funct3 == F_MULHSU) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign signed_b = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign a_neg    = signed_a && (op1_s < 0);
  assign b_neg    = signed_b && (op2_s < 0);
  assign a_mag    = cond_neg(a_neg, op1);
  assign b_mag    = cond_neg(b_neg, op2);
  assign div_zero = funct3[2] && (op2 == '0);
  assign div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                    (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? op1 : '1;
    else          special_res = funct3[1] ? '0 : op1;
  end

  // One iteration of multiply and divide, evaluated every cycle from the held state.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN+1:0]   div_shift, div_trial;
  logic              div_ok;
  logic [XLEN:0]     rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fin_res;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {rem, acc[XLEN-1]};
  assign div_trial = div_shift - {2'b00, mcand};
  assign div_ok    = ~div_trial[XLEN+1];
  assign rem_nxt   = div_ok ? div_trial[XLEN:0] : div_shift[XLEN:0];
  assign quo_nxt   = {acc[XLEN-2:0], div_ok};
  assign prod_fix  = cond_neg_wide(neg_res, mul_nxt);

  always_comb begin
    fin_res = '0;
    if (!f3[2])      fin_res = (f3 == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (!f3[1]) fin_res = cond_neg(neg_res, quo_nxt);
    else             fin_res = cond_neg(neg_rem, rem_nxt[XLEN-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    spec_ld   = 1'b0;
    stall_req = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall_req = rst && start;
        if (start && !flush) begin
          if (special) begin
            spec_ld   = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        stall_req = rst;
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_WIDTH'(XLEN-1)) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      mcand   <= '0;
      f3      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      if (load || spec_ld) begin
        cnt     <= '0;
        acc     <= {{XLEN{1'b0}}, a_mag};
        rem     <= '0;
        mcand   <= b_mag;
        f3      <= funct3;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
      end
      if (step) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        acc <= f3[2] ? {acc[2*XLEN-1:XLEN], quo_nxt} : mul_nxt;
      end
      if (finish)  result <= fin_res;
      if (spec_ld) result <= special_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected results, a monitor
// checks value and latency on every done pulse.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        stall_req, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
    logic [2:0]  f;
  } exp_t;
  exp_t sb[$];

  ex_muldiv_unit #(.XLEN(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .flush(flush), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no_done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("result_f%0d", e.f), result, e.res);
        check($sformatf("latency_f%0d", e.f), 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    #1;
    funct3 = f; op1 = a; op2 = b; start = 1'b1; flush = 1'b0;
    if (push) sb.push_back('{res: ref_res(f, a, b), cyc: cyc, lat: ref_lat(f, a, b), f: f});
    #1 check("stall_start", {31'b0, stall_req}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    issue(f, a, b, 1'b1);
    drain();
  endtask

  initial begin
    int   bad;
    int   dc;
    logic [31:0] held;
    logic [31:0] ra, rb;

    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   bad;
    int   dc;
    logic [31:0] held;
    logic [31:0] ra, rb;

    // Reset state, with start asserted to confirm stall_req stays low.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // MUL with stall_req held through CALC.
    @(posedge clk);
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);
    bad = 0;
    repeat (31) begin
      @(negedge clk);
      if (stall_req !== 1'b1) bad++;
    end
    check("stall_calc", 32'(bad), 32'd0);
    drain();

    run(3'd1, 32'h80000000, 32'h80000000);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'd2, 32'hFFFFFFFF, 32'd2);
    run(3'd5, 32'd100, 32'd7);
    run(3'd7, 32'd100, 32'd7);
    run(3'd4, 32'hFFFFFFF9, 32'd2);
    run(3'd6, 32'hFFFFFFF9, 32'd2);
    run(3'd4, 32'd5, 32'd0);
    run(3'd6, 32'd5, 32'd0);
    run(3'd5, 32'd5, 32'd0);
    run(3'd7, 32'd5, 32'd0);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF);

    // Flush ten cycles into a DIV: no done, result held.
    held = result;
    @(posedge clk);
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_stall", {31'b0, stall_req}, 32'd0);
    dc = done_cnt;
    repeat (40) @(posedge clk);
    check("flush_no_done", 32'(done_cnt), 32'(dc));
    check("flush_result_hold", result, held);

    // flush together with start in IDLE: not accepted.
    #1 funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_stall", {31'b0, stall_req}, 32'd0);
    dc = done_cnt;
    repeat (40) @(posedge clk);
    check("flush_start_no_done", 32'(done_cnt), 32'(dc));

    run(3'd0, 32'd3, 32'd4);

    // Asynchronous reset mid-MUL.
    @(posedge clk);
    issue(3'd0, 32'h1234, 32'h5678, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_stall", {31'b0, stall_req}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("arst_idle", {31'b0, stall_req}, 32'd0);
    run(3'd0, 32'd3, 32'd4);

    // start held high across two MULs; operand change during CALC is ignored.
    @(posedge clk);
    #1 funct3 = 3'd0; op1 = 32'd2; op2 = 32'd3; start = 1'b1;
    sb.push_back('{res: 32'd6, cyc: cyc, lat: 33, f: 3'd0});
    @(posedge clk);
    #1 op1 = 32'd4; op2 = 32'd5;
    bad = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin bad = 0; break; end
    end
    check("b2b_first_seen", 32'(bad), 32'd0);
    check("b2b_done_stall", {31'b0, stall_req}, 32'd0);
    @(posedge clk);
    #1 sb.push_back('{res: 32'd20, cyc: cyc, lat: 33, f: 3'd0});
    check("b2b_second_stall", {31'b0, stall_req}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // start and operands toggling during CALC have no effect.
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom;
      @(posedge clk);
      issue(3'(k + 4), ra, rb | 32'd1, 1'b1);
      repeat (20) begin
        @(posedge clk);
        #1 start = 1'($urandom_range(0, 1)); op1 = $urandom; op2 = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
      #1 start = 1'b0;
      drain();
    end

    // Randomized mix including boundary operands.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = $urandom_range(0, 20);
        2: ra = -$urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run(3'($urandom_range(0, 7)), ra, rb);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
